// File: rtl/regfile_sequencer_pkg.sv
// Shared encodings for the register-file command sequencer.
package regfile_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'd0,
    OP_READ  = 2'd1,
    OP_COPY  = 2'd2,
    OP_SWAP  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    WRI,
    RD0,
    RD1,
    WR0,
    WR1
  } state_t;

endpackage

// File: rtl/register_file.sv
// Small register file: one write port, two combinational read ports, synchronous active-high reset.
module register_file #(
  parameter int WIDTH      = 16,
  parameter int INDEX_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [INDEX_BITS-1:0] write_index,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [INDEX_BITS-1:0] read_index_a,
  output logic [WIDTH-1:0]      read_data_a,
  input  logic [INDEX_BITS-1:0] read_index_b,
  output logic [WIDTH-1:0]      read_data_b
);

  logic [WIDTH-1:0] regs [2**INDEX_BITS];

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
    end else if (write_enable) begin
      regs[write_index] <= write_data;
    end
  end

  assign read_data_a = regs[read_index_a];
  assign read_data_b = regs[read_index_b];

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven master for register_file: immediate write, read with response,
// register copy and register swap, one command at a time.
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int INDEX_BITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [INDEX_BITS-1:0] cmd_src,
  input  logic [INDEX_BITS-1:0] cmd_dst,
  input  logic [WIDTH-1:0]      cmd_data,
  output logic                  rsp_valid,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy,
  output logic [INDEX_BITS-1:0] write_index,
  output logic [WIDTH-1:0]      write_data,
  output logic                  write_enable,
  output logic [INDEX_BITS-1:0] read_index_a,
  input  logic [WIDTH-1:0]      read_data_a
);

  state_t                state;
  op_t                   op_q;
  logic [INDEX_BITS-1:0] src_q;
  logic [INDEX_BITS-1:0] dst_q;
  logic [WIDTH-1:0]      data_q;
  logic [WIDTH-1:0]      t0;
  logic [WIDTH-1:0]      t1;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= OP_WRITE;
      src_q     <= '0;
      dst_q     <= '0;
      data_q    <= '0;
      t0        <= '0;
      t1        <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= op_t'(cmd_op);
            src_q  <= cmd_src;
            dst_q  <= cmd_dst;
            data_q <= cmd_data;
            state  <= (op_t'(cmd_op) == OP_WRITE) ? WRI : RD0;
          end
        end
        WRI: state <= IDLE;
        RD0: begin
          t0 <= read_data_a;
          case (op_q)
            OP_READ: begin
              rsp_valid <= 1'b1;
              rsp_data  <= read_data_a;
              state     <= IDLE;
            end
            OP_COPY: state <= WR0;
            default: state <= RD1;
          endcase
        end
        RD1: begin
          t1    <= read_data_a;
          state <= WR0;
        end
        WR0:     state <= (op_q == OP_SWAP) ? WR1 : IDLE;
        WR1:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Port drive depends only on state and latched registers, so an async reset
  // removes write_enable in the same cycle.
  always_comb begin
    write_enable = 1'b0;
    write_index  = '0;
    write_data   = '0;
    read_index_a = '0;
    case (state)
      WRI: begin
        write_enable = 1'b1;
        write_index  = dst_q;
        write_data   = data_q;
      end
      RD0: read_index_a = src_q;
      RD1: read_index_a = dst_q;
      WR0: begin
        write_enable = 1'b1;
        write_index  = dst_q;
        write_data   = t0;
      end
      WR1: begin
        write_enable = 1'b1;
        write_index  = src_q;
        write_data   = t1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench: sequencer driving a register_file, READ results checked against a model.
module tb_regfile_sequencer;
  import regfile_sequencer_pkg::*;

  localparam int WIDTH      = 16;
  localparam int INDEX_BITS = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  rf_reset = 1'b1;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  logic [1:0]            cmd_op = '0;
  logic [INDEX_BITS-1:0] cmd_src = '0;
  logic [INDEX_BITS-1:0] cmd_dst = '0;
  logic [WIDTH-1:0]      cmd_data = '0;
  logic                  rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
  logic [INDEX_BITS-1:0] write_index;
  logic [WIDTH-1:0]      write_data;
  logic                  write_enable;
  logic [INDEX_BITS-1:0] read_index_a;
  logic [WIDTH-1:0]      read_data_a;
  logic [INDEX_BITS-1:0] read_index_b = '0;
  logic [WIDTH-1:0]      read_data_b;

  always #5 clk = ~clk;

  regfile_sequencer #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .write_index(write_index), .write_data(write_data), .write_enable(write_enable),
    .read_index_a(read_index_a), .read_data_a(read_data_a)
  );

  register_file #(.WIDTH(WIDTH), .INDEX_BITS(INDEX_BITS)) rf (
    .clk(clk), .reset(rf_reset),
    .write_enable(write_enable), .write_index(write_index), .write_data(write_data),
    .read_index_a(read_index_a), .read_data_a(read_data_a),
    .read_index_b(read_index_b), .read_data_b(read_data_b)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    int               due;
  } exp_t;

  int               tests  = 0;
  int               fails  = 0;
  int               cyc    = 0;
  int               we_cnt = 0;
  int               we0;
  logic [WIDTH-1:0] model [4] = '{default: '0};
  exp_t             sb [$];
  exp_t             got_e;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (write_enable) we_cnt++;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        got_e = sb.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(got_e.data));
        check("rsp_latency", 32'(cyc), 32'(got_e.due));
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready_busy_rsp"}, 32'({cmd_ready, busy, rsp_valid}), 32'b100);
    check({tag, "_rf_ports"}, 32'({write_enable, write_index, write_data, read_index_a}), 32'd0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
  endtask

  // Waits for cmd_ready, accepts the command on the next edge and updates the model.
  task automatic issue(input op_t op, input logic [1:0] src, input logic [1:0] dst,
                       input logic [WIDTH-1:0] data);
    int n = 0;
    exp_t e;
    logic [WIDTH-1:0] tmp;
    cmd_op = op; cmd_src = src; cmd_dst = dst; cmd_data = data; cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    case (op)
      OP_WRITE: model[dst] = data;
      OP_READ: begin
        e.data = model[src];
        e.due  = cyc + 2;
        sb.push_back(e);
      end
      OP_COPY: model[dst] = model[src];
      OP_SWAP: begin
        tmp        = model[src];
        model[src] = model[dst];
        model[dst] = tmp;
      end
      default: ;
    endcase
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_cycles, input string tag);
    int n = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  task automatic peek(input logic [1:0] idx, input string tag);
    read_index_b = idx;
    #1 check(tag, 32'(read_data_b), 32'(model[idx]));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    rf_reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_reset");

    we0 = we_cnt;
    issue(OP_WRITE, 2'd0, 2'd1, 16'd7);
    wait_done(1, "busy_write");
    check("write_pulses", 32'(we_cnt - we0), 32'd1);
    issue(OP_READ, 2'd1, 2'd0, '0);
    wait_done(1, "busy_read");

    issue(OP_WRITE, 2'd0, 2'd0, 16'd3);
    wait_done(1, "busy_write_r0");
    issue(OP_WRITE, 2'd0, 2'd2, 16'd9);
    wait_done(1, "busy_write_r2");
    issue(OP_COPY, 2'd0, 2'd2, '0);
    wait_done(2, "busy_copy");
    issue(OP_READ, 2'd2, 2'd0, '0);
    issue(OP_READ, 2'd0, 2'd0, '0);
    wait_done(1, "busy_read_b2b");

    issue(OP_WRITE, 2'd0, 2'd1, 16'd5);
    wait_done(1, "busy_write_r1");
    issue(OP_WRITE, 2'd0, 2'd3, 16'd12);
    wait_done(1, "busy_write_r3");
    issue(OP_SWAP, 2'd1, 2'd3, '0);
    @(negedge clk);
    check("swap_rd0", 32'({busy, write_enable, read_index_a}), 32'({1'b1, 1'b0, 2'd1}));
    @(negedge clk);
    check("swap_rd1", 32'({busy, write_enable, read_index_a}), 32'({1'b1, 1'b0, 2'd3}));
    @(negedge clk);
    check("swap_wr0", 32'({write_enable, write_index, write_data}), 32'({1'b1, 2'd3, 16'd5}));
    @(negedge clk);
    check("swap_wr1", 32'({write_enable, write_index, write_data}), 32'({1'b1, 2'd1, 16'd12}));
    @(negedge clk);
    check("swap_done_ready", 32'(cmd_ready), 32'd1);
    issue(OP_READ, 2'd1, 2'd0, '0);
    issue(OP_READ, 2'd3, 2'd0, '0);
    wait_done(1, "busy_read_swap");

    issue(OP_SWAP, 2'd1, 2'd3, '0);
    we0 = we_cnt;
    cmd_op = OP_WRITE; cmd_dst = 2'd0; cmd_data = 16'hFFFF; cmd_valid = 1'b1;
    wait_done(4, "busy_swap_hold");
    check("swap_write_pulses", 32'(we_cnt - we0), 32'd2);
    issue(OP_WRITE, 2'd0, 2'd0, 16'hFFFF);
    wait_done(1, "busy_held_write");
    issue(OP_READ, 2'd0, 2'd0, '0);
    wait_done(1, "busy_read_r0");
    issue(OP_SWAP, 2'd2, 2'd2, '0);
    wait_done(4, "busy_swap_same");
    issue(OP_READ, 2'd2, 2'd0, '0);
    wait_done(1, "busy_read_r2");

    issue(OP_WRITE, 2'd0, 2'd1, 16'd4);
    wait_done(1, "busy_write_r1_4");
    issue(OP_WRITE, 2'd0, 2'd3, 16'd8);
    wait_done(1, "busy_write_r3_8");
    issue(OP_SWAP, 2'd1, 2'd3, '0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("we_in_wr0", 32'(write_enable), 32'd1);
    reset = 1'b0;
    #1;
    check("we_drop_on_reset", 32'({write_enable, busy}), 32'd0);
    // Reset lands before the WR0 edge, so neither swap write takes effect.
    model[1] = 16'd4;
    model[3] = 16'd8;
    repeat (2) @(negedge clk);
    check_idle_outputs("mid_reset");
    reset = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_mid_reset");
    peek(2'd1, "abort_r1");
    peek(2'd3, "abort_r3");
    issue(OP_READ, 2'd3, 2'd0, '0);
    wait_done(1, "busy_read_after_abort");

    @(negedge clk);
    for (int i = 0; i < 4; i++) peek(2'(i), "final_reg");
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
